shift_right_seq: RTL and testbench

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

---
 rtl/shift_right_seq.sv | 76 +++++++
 tb/tb_shift_right_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// Sequential 16-bit right shifter: one bit per clock, logical or arithmetic.
// The operand, shift amount and fill mode are captured on an accepted start.
// The register shifts once per cycle while the counter is nonzero, then a
// one-cycle done pulse follows. busy and done are decoded from the state only.
module shift_right_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        arith,
  input  logic [15:0] data_in,
  input  logic [3:0]  shamt,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        arith_q, arith_d;

  // Next state and datapath. Everything holds unless a transition says otherwise.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = data_in;
          cnt_d   = shamt;
          arith_d = arith;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd0) begin
          // The fill bit is the old MSB in arithmetic mode, and zero otherwise.
          sr_d  = {arith_q & sr_q[15], sr_q[15:1]};
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Synchronous reset wins over any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end

  assign data_out = sr_q;
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq. The stimulus process pushes the
// expected result, the shift amount and the capture cycle for each accepted
// start. The monitor pops an entry on every done pulse and checks the result,
// the done latency and the length of the busy run.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        arith;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  shift_right_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .arith    (arith),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    int          n;
    int          cap;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    busy_run = 0;
  bit    mon_en = 1'b0;

  // Counts rising edges so latencies can be measured in whole cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: this runs at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && done) begin
        checks++; errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
      end
      if (busy) busy_run++;
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=1 data_out=%h at cycle %0d, required no pulse", data_out, cyc);
        end else begin
          item_t it;
          it = q.pop_front();
          if (data_out !== it.exp) begin
            errors++;
            $display("FAIL result: data_out=%h, required %h (N=%0d)", data_out, it.exp, it.n);
          end
          checks++;
          if (cyc != it.cap + it.n + 2) begin
            errors++;
            $display("FAIL latency: done at cycle %0d, required %0d (N=%0d)", cyc, it.cap + it.n + 2, it.n);
          end
          checks++;
          if (busy_run != it.n + 1) begin
            errors++;
            $display("FAIL busy_len: busy for %0d cycles, required %0d", busy_run, it.n + 1);
          end
        end
        busy_run = 0;
      end else if (!busy) begin
        busy_run = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] d, input logic [3:0] s, input logic a,
                       input logic [15:0] exp);
    item_t it;
    @(negedge clk);
    data_in = d; shamt = s; arith = a; start = 1'b1;
    it.exp = exp; it.n = int'(s); it.cap = cyc;
    q.push_back(it);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for the scoreboard to drain. When scramble is set, the inputs
  // (start included) are changed while the operation runs.
  task automatic wait_idle(input bit scramble);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin ok = 1'b1; break; end
      if (scramble) begin
        data_in = 16'($urandom); shamt = 4'($urandom); arith = 1'($urandom);
        start = 1'($urandom);
      end
    end
    start = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL timeout: %0d operations pending after 100 cycles, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input string name);
    checks++;
    if (data_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: data_out=%h busy=%b done=%b, required 0000 0 0", name, data_out, busy, done);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  s;
    logic        a;
    logic [15:0] e;

    reset = 1'b1; start = 1'b1; arith = 1'b1; data_in = 16'hFFFF; shamt = 4'hF;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    reset = 1'b0; start = 1'b0;
    mon_en = 1'b1;

    // Directed vectors with hand-computed results.
    issue(16'h8000, 4'd15, 1'b0, 16'h0001); wait_idle(1'b0);
    issue(16'h8000, 4'd15, 1'b1, 16'hFFFF); wait_idle(1'b0);
    issue(16'h7F00, 4'd4,  1'b1, 16'h07F0); wait_idle(1'b0);
    issue(16'h1234, 4'd0,  1'b0, 16'h1234); wait_idle(1'b0);
    issue(16'h1234, 4'd0,  1'b1, 16'h1234); wait_idle(1'b0);
    issue(16'hFFFF, 4'd1,  1'b0, 16'h7FFF); wait_idle(1'b0);
    issue(16'h8001, 4'd1,  1'b1, 16'hC000); wait_idle(1'b0);

    // The result must hold in IDLE until the next accepted start.
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 16'hC000) begin
      errors++;
      $display("FAIL hold_idle: data_out=%h, required c000", data_out);
    end

    // A second start while busy must be ignored.
    issue(16'hA5A5, 4'd8, 1'b0, 16'h00A5);
    @(negedge clk);
    data_in = 16'hFFFF; shamt = 4'd1; arith = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);

    // Reset partway through an operation aborts it without a done pulse.
    issue(16'hABCD, 4'd10, 1'b1, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check_idle_zero("reset_abort");
    // Deassert reset and start together: the start must be accepted at that edge.
    begin
      item_t it;
      reset = 1'b0; data_in = 16'hABCD; shamt = 4'd4; arith = 1'b0; start = 1'b1;
      it.exp = 16'h0ABC; it.n = 4; it.cap = cyc;
      q.push_back(it);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(1'b0);

    // Random sweep. Inputs are scrambled while each operation runs.
    for (int k = 0; k < 1000; k++) begin
      d = 16'($urandom); s = 4'($urandom); a = 1'($urandom);
      e = a ? 16'($signed(d) >>> s) : (d >> s);
      issue(d, s, a, e);
      wait_idle(1'b1);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
